// File: rtl/vTPU_pkg.sv
// Shared types for the weight preload path.
//   MATRIX_WIDTH       systolic array dimension (rows per tile, bytes per row)
//   BYTE_TYPE          one weight byte
//   WEIGHT_ROW_TYPE    one weight-buffer row, MATRIX_WIDTH bytes
//   WEIGHT_ARRAY_TYPE  one full tile, MATRIX_WIDTH rows
//   WEIGHT_PRELOAD_STATE_TYPE  shadow-bank fill state
package vTPU_pkg;
  localparam int MATRIX_WIDTH    = 14;
  localparam int BYTE_WIDTH      = 8;
  localparam int ROW_INDEX_WIDTH = $clog2(MATRIX_WIDTH);
  localparam int COUNT_WIDTH     = $clog2(MATRIX_WIDTH + 1);

  typedef logic [BYTE_WIDTH-1:0]                  BYTE_TYPE;
  typedef BYTE_TYPE       [0:MATRIX_WIDTH-1]      WEIGHT_ROW_TYPE;
  typedef WEIGHT_ROW_TYPE [0:MATRIX_WIDTH-1]      WEIGHT_ARRAY_TYPE;

  typedef enum logic [1:0] {
    WP_EMPTY   = 2'd0,
    WP_FILLING = 2'd1,
    WP_READY   = 2'd2
  } WEIGHT_PRELOAD_STATE_TYPE;
endpackage

// File: rtl/weight_bank.sv
// One MATRIX_WIDTH x MATRIX_WIDTH weight bank.
//   clk    clock
//   clear  synchronous clear of the whole array (highest priority)
//   we     write enable for row waddr
//   waddr  row index, must be < MATRIX_WIDTH when we is high
//   wdata  row data
//   rdata  full-array read, registered contents
module weight_bank
  import vTPU_pkg::*;
(
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       we,
  input  logic [ROW_INDEX_WIDTH-1:0] waddr,
  input  WEIGHT_ROW_TYPE             wdata,
  output WEIGHT_ARRAY_TYPE           rdata
);
  always_ff @(posedge clk) begin
    if (clear) begin
      rdata <= '0;
    end else if (we) begin
      rdata[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/weight_preload_buffer.sv
// Double-buffered weight store. Rows are written into the shadow bank while
// the array reads the active bank; a switch handshake swaps the banks so a
// whole tile changes at once.
//   clk, rst         clock, synchronous active-high reset
//   enable           global stall; state holds while low (rst still acts)
//   load_weight      write weight_data into shadow row weight_address
//   weight_address   target row; values >= MATRIX_WIDTH are ignored
//   weight_signed    signedness of the tile being loaded
//   weight_data      one row of weights
//   switch_req       level request to swap banks
//   switch_ack       one-cycle pulse in the cycle the swap is visible
//   active_weights   active bank contents
//   active_signed    signedness of the active bank
//   shadow_count     number of distinct shadow rows written
//   busy             shadow partly/fully filled or switch pending
//   fsm_state        current fill state (WEIGHT_PRELOAD_STATE_TYPE encoding)
//   load_error       only with WEIGHT_PRELOAD_CHECK_EN: sticky misuse flag
//
// Handshake: switch_req is a level held by the requester. The swap happens at
// the first clock edge where state is READY, switch_req is high and enable is
// high; switch_ack is high for exactly the following cycle, together with the
// new active_weights/active_signed. A switch_req still high after the ack
// cycle is a request for the next tile.
module weight_preload_buffer
  import vTPU_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   load_weight,
  input  logic [BYTE_WIDTH-1:0]  weight_address,
  input  logic                   weight_signed,
  input  WEIGHT_ROW_TYPE         weight_data,
  input  logic                   switch_req,
  output logic                   switch_ack,
  output WEIGHT_ARRAY_TYPE       active_weights,
  output logic                   active_signed,
  output logic [COUNT_WIDTH-1:0] shadow_count,
  output logic                   busy,
  output logic [1:0]             fsm_state
`ifdef WEIGHT_PRELOAD_CHECK_EN
  ,
  output logic                   load_error
`endif
);
  WEIGHT_PRELOAD_STATE_TYPE state, state_next;
  logic [MATRIX_WIDTH-1:0]  row_valid, row_valid_next;
  logic [COUNT_WIDTH-1:0]   count_next;
  logic                     bank_ptr;       // index of the active bank
  logic                     shadow_signed;
  logic                     addr_ok;
  logic                     write_en;
  logic                     swap;
  logic                     write_sel;      // bank that receives this cycle's write
  logic [ROW_INDEX_WIDTH-1:0] addr_idx;
  WEIGHT_ARRAY_TYPE         bank_rd0, bank_rd1;

  assign addr_ok  = weight_address < BYTE_WIDTH'(MATRIX_WIDTH);
  assign addr_idx = weight_address[ROW_INDEX_WIDTH-1:0];
  assign write_en = load_weight && enable && addr_ok;
  assign swap     = (state == WP_READY) && switch_req && enable;
  // On a swap the old active bank becomes the new shadow, so a concurrent
  // write lands there as the first row of the next tile.
  assign write_sel = swap ? bank_ptr : ~bank_ptr;

  always_comb begin
    state_next     = state;
    row_valid_next = row_valid;
    count_next     = shadow_count;
    if (swap) begin
      row_valid_next = '0;
      count_next     = '0;
      state_next     = WP_EMPTY;
      if (write_en) begin
        row_valid_next[addr_idx] = 1'b1;
        count_next               = COUNT_WIDTH'(1);
        state_next               = WP_FILLING;
      end
    end else if (write_en) begin
      row_valid_next[addr_idx] = 1'b1;
      if (!row_valid[addr_idx]) begin
        count_next = shadow_count + COUNT_WIDTH'(1);
      end
      // Looking at the updated valid mask makes READY visible in the cycle
      // right after the final row write.
      if (state != WP_READY) begin
        state_next = (&row_valid_next) ? WP_READY : WP_FILLING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WP_EMPTY;
      row_valid     <= '0;
      shadow_count  <= '0;
      bank_ptr      <= 1'b0;
      shadow_signed <= 1'b0;
      active_signed <= 1'b0;
      switch_ack    <= 1'b0;
    end else begin
      // The ack is a pulse, so it is not held across a stall.
      switch_ack <= swap;
      if (enable) begin
        state        <= state_next;
        row_valid    <= row_valid_next;
        shadow_count <= count_next;
        if (swap) begin
          bank_ptr      <= ~bank_ptr;
          active_signed <= shadow_signed;
        end
        if (write_en) begin
          shadow_signed <= weight_signed;
        end
      end
    end
  end

  weight_bank u_bank0 (
    .clk   (clk),
    .clear (rst),
    .we    (write_en && (write_sel == 1'b0)),
    .waddr (addr_idx),
    .wdata (weight_data),
    .rdata (bank_rd0)
  );

  weight_bank u_bank1 (
    .clk   (clk),
    .clear (rst),
    .we    (write_en && (write_sel == 1'b1)),
    .waddr (addr_idx),
    .wdata (weight_data),
    .rdata (bank_rd1)
  );

  assign active_weights = bank_ptr ? bank_rd1 : bank_rd0;
  assign busy           = (shadow_count != '0) || switch_req;
  assign fsm_state      = state;

`ifdef WEIGHT_PRELOAD_CHECK_EN
  logic req_q;
  logic err_bad_addr, err_rewrite, err_early_req;

  assign err_bad_addr  = enable && load_weight && !addr_ok;
  assign err_rewrite   = write_en && (state == WP_FILLING) && row_valid[addr_idx];
  assign err_early_req = switch_req && !req_q && (state == WP_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      load_error <= 1'b0;
    end else begin
      req_q <= switch_req;
      if (err_bad_addr || err_rewrite || err_early_req) begin
        load_error <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && (err_bad_addr || err_rewrite || err_early_req)) begin
      $display("weight_preload_buffer: load error (bad_addr=%0b rewrite=%0b early_req=%0b) at %0t",
               err_bad_addr, err_rewrite, err_early_req, $time);
    end
  end
`endif
`endif
endmodule

// File: tb/tb_weight_preload_buffer.sv
module tb_weight_preload_buffer;
  import vTPU_pkg::*;

  localparam int EXP_W = 1 + COUNT_WIDTH + MATRIX_WIDTH * MATRIX_WIDTH * BYTE_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   enable = 1'b1;
  logic                   load_weight = 1'b0;
  logic [BYTE_WIDTH-1:0]  weight_address = '0;
  logic                   weight_signed = 1'b0;
  WEIGHT_ROW_TYPE         weight_data = '0;
  logic                   switch_req = 1'b0;
  logic                   switch_ack;
  WEIGHT_ARRAY_TYPE       active_weights;
  logic                   active_signed;
  logic [COUNT_WIDTH-1:0] shadow_count;
  logic                   busy;
  logic [1:0]             fsm_state;
`ifdef WEIGHT_PRELOAD_CHECK_EN
  logic                   load_error;
`endif

  weight_preload_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .load_weight    (load_weight),
    .weight_address (weight_address),
    .weight_signed  (weight_signed),
    .weight_data    (weight_data),
    .switch_req     (switch_req),
    .switch_ack     (switch_ack),
    .active_weights (active_weights),
    .active_signed  (active_signed),
    .shadow_count   (shadow_count),
    .busy           (busy),
    .fsm_state      (fsm_state)
`ifdef WEIGHT_PRELOAD_CHECK_EN
    ,
    .load_error     (load_error)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic WEIGHT_ARRAY_TYPE tile(input logic [7:0] base, input int sp_row,
                                            input logic [7:0] sp_val);
    WEIGHT_ARRAY_TYPE t;
    for (int r = 0; r < MATRIX_WIDTH; r++)
      for (int c = 0; c < MATRIX_WIDTH; c++)
        t[r][c] = (r == sp_row) ? sp_val : base + 8'(r);
    return t;
  endfunction

  task automatic push_exp(input WEIGHT_ARRAY_TYPE arr, input logic sgn,
                          input logic [COUNT_WIDTH-1:0] cnt);
    exp_q.push_back({sgn, cnt, arr});
  endtask

  // Monitor: every ack must match the next expected tile.
  always @(negedge clk) begin
    if (!rst && switch_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack with no pending switch at %0t", $time);
      end else begin
        logic [EXP_W-1:0] e;
        WEIGHT_ARRAY_TYPE ea;
        e  = exp_q.pop_front();
        ea = e[MATRIX_WIDTH*MATRIX_WIDTH*BYTE_WIDTH-1:0];
        if ({active_signed, shadow_count, active_weights} !== e) begin
          bad++;
          $display("FAIL ack_tile: got signed=%0b count=%0d expected signed=%0b count=%0d at %0t",
                   active_signed, shadow_count, e[EXP_W-1],
                   e[EXP_W-2 -: COUNT_WIDTH], $time);
          for (int r = 0; r < MATRIX_WIDTH; r++) begin
            if (active_weights[r] !== ea[r]) begin
              $display("FAIL ack_tile_row%0d: got %h expected %h", r, active_weights[r], ea[r]);
              break;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] val, input logic sgn);
    load_weight    = 1'b1;
    weight_address = 8'(addr);
    weight_signed  = sgn;
    for (int c = 0; c < MATRIX_WIDTH; c++) weight_data[c] = val;
    tick();
    load_weight = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("rst_ack",    64'(switch_ack),    64'd0);
    chk("rst_busy",   64'(busy),          64'd0);
    chk("rst_count",  64'(shadow_count),  64'd0);
    chk("rst_signed", 64'(active_signed), 64'd0);
    chk("rst_state",  64'(fsm_state),     64'(WP_EMPTY));
    chk("rst_active_zero", 64'(active_weights == '0), 64'd1);

    // 1: full tile then switch
    for (int r = 0; r < MATRIX_WIDTH; r++) wr(r, 8'(r + 1), 1'b1);
    chk("t1_state_ready", 64'(fsm_state),    64'(WP_READY));
    chk("t1_count_full",  64'(shadow_count), 64'd14);
    chk("t1_old_active",  64'(active_weights[5][0]), 64'h00);
    push_exp(tile(8'h01, -1, 8'h00), 1'b1, '0);
    switch_req = 1'b1;
    tick();
    chk("t1_ack",        64'(switch_ack),            64'd1);
    chk("t1_row5",       64'(active_weights[5][13]), 64'h06);
    chk("t1_signed",     64'(active_signed),         64'd1);
    chk("t1_count_zero", 64'(shadow_count),          64'd0);
    switch_req = 1'b0;
    tick();
    chk("t1_ack_pulse",  64'(switch_ack), 64'd0);
    chk("t1_busy_idle",  64'(busy),       64'd0);
    chk("t1_state_empty", 64'(fsm_state), 64'(WP_EMPTY));

    // 2: request raised while filling
    for (int r = 0; r < 3; r++) wr(r, 8'h10 + 8'(r), 1'b0);
    push_exp(tile(8'h10, -1, 8'h00), 1'b0, '0);
    switch_req = 1'b1;
    for (int r = 3; r < MATRIX_WIDTH; r++) begin
      wr(r, 8'h10 + 8'(r), 1'b0);
      chk($sformatf("t2_no_ack_r%0d", r), 64'(switch_ack), 64'd0);
      chk($sformatf("t2_busy_r%0d", r),   64'(busy),       64'd1);
    end
    chk("t2_active_still_a", 64'(active_weights[0][0]), 64'h01);
    tick();
    chk("t2_ack", 64'(switch_ack), 64'd1);
    chk("t2_busy_at_ack", 64'(busy), 64'd1);
    switch_req = 1'b0;
    tick();
    chk("t2_ack_pulse", 64'(switch_ack), 64'd0);

    // 3: swap and write in the same cycle
    for (int r = 0; r < MATRIX_WIDTH; r++) wr(r, 8'h20 + 8'(r), 1'b1);
    push_exp(tile(8'h20, -1, 8'h00), 1'b1, COUNT_WIDTH'(1));
    switch_req = 1'b1;
    wr(7, 8'hAA, 1'b0);
    chk("t3_ack",   64'(switch_ack),   64'd1);
    chk("t3_count", 64'(shadow_count), 64'd1);
    chk("t3_state", 64'(fsm_state),    64'(WP_FILLING));
    switch_req = 1'b0;
    for (int r = 0; r < MATRIX_WIDTH; r++)
      if (r != 7) wr(r, 8'h30 + 8'(r), 1'b0);
    chk("t3_state_ready", 64'(fsm_state),    64'(WP_READY));
    chk("t3_count_full",  64'(shadow_count), 64'd14);

    // 4: stall while READY with a pending switch
    push_exp(tile(8'h30, 7, 8'hAA), 1'b0, '0);
    switch_req = 1'b1;
    enable     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_no_ack_%0d", i), 64'(switch_ack),           64'd0);
      chk($sformatf("t4_held_%0d", i),   64'(active_weights[0][0]), 64'h20);
      chk($sformatf("t4_state_%0d", i),  64'(fsm_state),            64'(WP_READY));
    end
    enable = 1'b1;
    tick();
    chk("t4_ack",       64'(switch_ack),           64'd1);
    chk("t4_row7",      64'(active_weights[7][3]), 64'hAA);
    chk("t4_row8",      64'(active_weights[8][3]), 64'h38);
    switch_req = 1'b0;
    tick();

    // 5: reset in the middle of a fill
    for (int r = 0; r < 9; r++) wr(r, 8'h50 + 8'(r), 1'b1);
    chk("t5_count_nine", 64'(shadow_count), 64'd9);
    do_reset();
    chk("t5_count", 64'(shadow_count), 64'd0);
    chk("t5_busy",  64'(busy),         64'd0);
    chk("t5_active_zero", 64'(active_weights == '0), 64'd1);
    chk("t5_state", 64'(fsm_state),    64'(WP_EMPTY));
    wr(14, 8'h77, 1'b1);
    chk("t5_bad_addr_count", 64'(shadow_count), 64'd0);
    chk("t5_bad_addr_state", 64'(fsm_state),    64'(WP_EMPTY));
    switch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_no_ack_%0d", i), 64'(switch_ack), 64'd0);
    end
    switch_req = 1'b0;
    tick();

`ifdef WEIGHT_PRELOAD_CHECK_EN
    // 6: sticky error on an out-of-range address
    do_reset();
    chk("t6_err_clear", 64'(load_error), 64'd0);
    wr(20, 8'h99, 1'b0);
    chk("t6_err_set",   64'(load_error),   64'd1);
    chk("t6_no_write",  64'(shadow_count), 64'd0);
    tick();
    tick();
    chk("t6_err_sticky", 64'(load_error), 64'd1);
    do_reset();
    chk("t6_err_rst", 64'(load_error), 64'd0);
`endif

    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
